// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, instruction-field and fetch-state definitions
// Purpose: opcode enum, instruction field positions/widths, fetch FSM states
//          and the illegal-opcode helper used by the fetch/decode slice.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic [3:0] {
    ADD      = 4'd0,
    SUBTRACT = 4'd1,
    AND_OP   = 4'd2,
    OR_OP    = 4'd3,
    XOR_OP   = 4'd4,
    NOT_OP   = 4'd5,
    LOAD     = 4'd6,
    STORE    = 4'd7,
    NOP      = 4'd15
  } opcode_t;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 4;
  localparam int RD_W    = 2;
  localparam int RS_LSB  = 6;
  localparam int RS_W    = 2;
  localparam int IMM_LSB = 8;
  localparam int IMM_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Opcodes 8..14 are unassigned; 15 is the architectural NOP.
  function automatic logic is_illegal(input logic [OPC_W-1:0] op);
    return (op >= 4'd8) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// rtl/fetch_decode_unit_if.sv - program-memory and decoded-slot bus
// Purpose: groups the program_memory address/data pair and the decoded
//          valid/ready slot toward the execute stage.
// Ports:   master = fetch/decode unit, slave = memory + execute side.
interface fetch_decode_unit_if import cpu_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] instruction_address;
  logic [DATA_W-1:0] instruction;
  logic              dec_valid;
  logic              dec_ready;
  logic [OPC_W-1:0]  dec_opcode;
  logic [RD_W-1:0]   dec_rd;
  logic [RS_W-1:0]   dec_rs;
  logic [IMM_W-1:0]  dec_imm;
  logic              dec_illegal;
  logic [ADDR_W-1:0] dec_pc;

  modport master (
    output instruction_address, dec_valid, dec_opcode, dec_rd, dec_rs,
           dec_imm, dec_illegal, dec_pc,
    input  instruction, dec_ready
  );

  modport slave (
    input  instruction_address, dec_valid, dec_opcode, dec_rd, dec_rs,
           dec_imm, dec_illegal, dec_pc,
    output instruction, dec_ready
  );

endinterface

// File: rtl/instr_field_decoder.sv
// rtl/instr_field_decoder.sv - combinational instruction word field splitter
// Purpose: word -> opcode/rd/rs/imm plus illegal-opcode flag.
// Ports:   word (in), opcode/rd/rs/imm/illegal (out).
module instr_field_decoder import cpu_pkg::*; #(
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic [INSTRUCTION_WIDTH-1:0] word,
  output logic [OPC_W-1:0]             opcode,
  output logic [RD_W-1:0]              rd,
  output logic [RS_W-1:0]              rs,
  output logic [IMM_W-1:0]             imm,
  output logic                         illegal
);

  assign opcode  = word[OPC_LSB +: OPC_W];
  assign rd      = word[RD_LSB  +: RD_W];
  assign rs      = word[RS_LSB  +: RS_W];
  assign imm     = word[IMM_LSB +: IMM_W];
  assign illegal = is_illegal(opcode);

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC owner, instruction fetch and decoded slot register
// Purpose: drives program_memory from pc, captures and decodes one word per
//          cycle into a valid/ready slot for the execute stage.
// Ports:   clk, rst (async, active-high), start (pulse), halt (level),
//          done (sticky), bus (fetch_decode_unit_if.master).
//          Optional macro FETCH_JUMP_EN adds jump_en/jump_addr.
module fetch_decode_unit import cpu_pkg::*; #(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
`ifdef FETCH_JUMP_EN
  input  logic                 jump_en,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] jump_addr,
`endif
  output logic                 done,
  fetch_decode_unit_if.master  bus
);

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_ADDR =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);

  fetch_state_t state_q, state_d;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_q;
  logic                             done_q;

  logic                             valid_q;
  logic [OPC_W-1:0]                 opc_q;
  logic [RD_W-1:0]                  rd_q;
  logic [RS_W-1:0]                  rs_q;
  logic [IMM_W-1:0]                 imm_q;
  logic                             ill_q;
  logic [BITS_FOR_INSTRUCTIONS-1:0] slot_pc_q;

  logic [OPC_W-1:0] f_opc;
  logic [RD_W-1:0]  f_rd;
  logic [RS_W-1:0]  f_rs;
  logic [IMM_W-1:0] f_imm;
  logic             f_ill;

  logic                             jump_hit;
  logic [BITS_FOR_INSTRUCTIONS-1:0] jump_target;
  logic                             capture;
  logic                             at_last;

`ifdef FETCH_JUMP_EN
  // A jump is honoured from RUN and also from DONE (restarts fetching).
  assign jump_hit    = jump_en && (state_q != IDLE);
  assign jump_target = jump_addr;
`else
  assign jump_hit    = 1'b0;
  assign jump_target = pc_q;
`endif

  assign at_last = (pc_q == LAST_ADDR);
  assign capture = (state_q == RUN) && !halt && !jump_hit &&
                   (!valid_q || bus.dec_ready);

  instr_field_decoder #(.INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)) u_dec (
    .word    (bus.instruction),
    .opcode  (f_opc),
    .rd      (f_rd),
    .rs      (f_rs),
    .imm     (f_imm),
    .illegal (f_ill)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !halt && !done_q) state_d = RUN;
      RUN: begin
        if (jump_hit)               state_d = RUN;
        else if (halt)              state_d = IDLE;
        else if (capture && at_last) state_d = DONE;
      end
      DONE: if (jump_hit) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      opc_q     <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      ill_q     <= 1'b0;
      slot_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (jump_hit) begin
        pc_q    <= jump_target;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (capture) begin
        valid_q   <= 1'b1;
        opc_q     <= f_opc;
        rd_q      <= f_rd;
        rs_q      <= f_rs;
        imm_q     <= f_imm;
        ill_q     <= f_ill;
        slot_pc_q <= pc_q;
        // pc parks on the last address instead of wrapping.
        if (at_last) done_q <= 1'b1;
        else         pc_q   <= pc_q + 1'b1;
      end else if (bus.dec_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.instruction_address = pc_q;
  assign bus.dec_valid           = valid_q;
  assign bus.dec_opcode          = opc_q;
  assign bus.dec_rd              = rd_q;
  assign bus.dec_rs              = rs_q;
  assign bus.dec_imm             = imm_q;
  assign bus.dec_illegal         = ill_q;
  assign bus.dec_pc              = slot_pc_q;
  assign done                    = done_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic clk;
  logic rst;
  logic start;
  logic halt;
  logic done;
`ifdef FETCH_JUMP_EN
  logic       jump_en;
  logic [4:0] jump_addr;
`endif

  logic [15:0] mem [32];
  int n_cmp;
  int n_fail;
  int exp_next;
  int guard;
  logic [4:0] hold_pc;
  logic [7:0] hold_imm;
  logic       hold_chk;

  fetch_decode_unit_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  assign bus.instruction = mem[bus.instruction_address];

  fetch_decode_unit #(
    .BITS_FOR_INSTRUCTIONS (5),
    .INSTRUCTION_WIDTH     (16),
    .NUMBER_OF_INSTRUCTIONS(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .halt  (halt),
`ifdef FETCH_JUMP_EN
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
`endif
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: transfers must deliver addresses 0,1,2,... exactly once, in
  // order, with fields cut from the memory word by plain arithmetic.
  task automatic xfer();
    int w;
    int op;
    w  = int'(mem[exp_next % 32]);
    op = w % 16;
    chk("xfer_pc",      32'(bus.dec_pc),      32'(exp_next));
    chk("xfer_opcode",  32'(bus.dec_opcode),  32'(op));
    chk("xfer_rd",      32'(bus.dec_rd),      32'((w / 16) % 4));
    chk("xfer_rs",      32'(bus.dec_rs),      32'((w / 64) % 4));
    chk("xfer_imm",     32'(bus.dec_imm),     32'(w / 256));
    chk("xfer_illegal", 32'(bus.dec_illegal), 32'((op >= 8 && op <= 14) ? 1 : 0));
    exp_next++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; halt = 1'b0;
    bus.dec_ready = 1'b1;
`ifdef FETCH_JUMP_EN
    jump_en = 1'b0; jump_addr = '0;
`endif
    n_cmp = 0; n_fail = 0; exp_next = 0;
    for (int i = 0; i < 32; i++) mem[i] = {8'(i), 2'b01, 2'b10, 4'd0};

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(bus.dec_valid), 0);
    chk("rst_addr",  32'(bus.instruction_address), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_fields", {bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm,
                       bus.dec_illegal, bus.dec_pc}, 0);
    rst = 1'b0;

    // Full back-to-back run of ADD words with dec_ready held high
    start = 1'b1; tick(); start = 1'b0;
    chk("start_valid0", 32'(bus.dec_valid), 0);
    tick();
    chk("first_valid", 32'(bus.dec_valid), 1);
    for (int i = 0; i < 32; i++) begin
      chk("run_valid", 32'(bus.dec_valid), 1);
      chk("run_addr",  32'(bus.instruction_address), 32'((i < 31) ? i + 1 : 31));
      chk("run_done",  32'(done), 32'((i == 31) ? 1 : 0));
      xfer();
      tick();
    end
    chk("end_valid", 32'(bus.dec_valid), 0);
    chk("end_done",  32'(done), 1);
    chk("end_addr",  32'(bus.instruction_address), 31);

    // Randomized program with directed decode, stall and halt cases
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_done", 32'(done), 0);
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    mem[2] = {8'd10, 2'b10, 2'b00, 4'b0110};
    mem[3] = {8'd55, 2'b11, 2'b01, 4'b1010};
    exp_next = 0;
    bus.dec_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick();
    guard = 0;
    while (!(bus.dec_valid && bus.dec_pc == 5'd4) && guard < 50) begin
      if (bus.dec_valid) begin
        if (bus.dec_pc == 5'd2) begin
          chk("w2_opcode", 32'(bus.dec_opcode), 6);
          chk("w2_rd",     32'(bus.dec_rd), 0);
          chk("w2_rs",     32'(bus.dec_rs), 2);
          chk("w2_imm",    32'(bus.dec_imm), 10);
          chk("w2_illegal", 32'(bus.dec_illegal), 0);
        end
        if (bus.dec_pc == 5'd3) chk("w3_illegal", 32'(bus.dec_illegal), 1);
        xfer();
      end
      tick(); guard++;
    end
    chk("reach_pc4", 32'(guard < 50), 1);

    bus.dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 32'(bus.dec_valid), 1);
      chk("stall_pc",    32'(bus.dec_pc), 4);
      chk("stall_imm",   32'(bus.dec_imm), 32'(mem[4][15:8]));
      chk("stall_addr",  32'(bus.instruction_address), 5);
    end
    bus.dec_ready = 1'b1;
    guard = 0;
    while (bus.instruction_address != 5'd7 && guard < 50) begin
      if (bus.dec_valid) xfer();
      tick(); guard++;
    end
    chk("reach_addr7", 32'(guard < 50), 1);

    halt = 1'b1; bus.dec_ready = 1'b0; tick();
    chk("halt_pending_valid", 32'(bus.dec_valid), 1);
    chk("halt_pending_pc",    32'(bus.dec_pc), 6);
    chk("halt_addr",          32'(bus.instruction_address), 7);
    bus.dec_ready = 1'b1; xfer(); tick();
    chk("halt_drained", 32'(bus.dec_valid), 0);
    chk("halt_addr2",   32'(bus.instruction_address), 7);
    start = 1'b1; tick(); start = 1'b0;
    chk("halt_wins_valid", 32'(bus.dec_valid), 0);
    chk("halt_wins_addr",  32'(bus.instruction_address), 7);
    halt = 1'b0; tick();
    chk("idle_addr", 32'(bus.instruction_address), 7);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("resume_valid", 32'(bus.dec_valid), 1);
    chk("resume_pc",    32'(bus.dec_pc), 7);

    guard = 0;
    while (exp_next < 32 && guard < 600) begin
      bus.dec_ready = 1'($urandom_range(0, 1));
      hold_chk = bus.dec_valid && !bus.dec_ready;
      hold_pc  = bus.dec_pc;
      hold_imm = bus.dec_imm;
      if (bus.dec_valid && bus.dec_ready) xfer();
      tick(); guard++;
      if (hold_chk) begin
        chk("hold_valid", 32'(bus.dec_valid), 1);
        chk("hold_pc",    32'(bus.dec_pc), 32'(hold_pc));
        chk("hold_imm",   32'(bus.dec_imm), 32'(hold_imm));
      end
    end
    chk("rand_count", 32'(exp_next), 32);
    chk("rand_done",  32'(done), 1);
    chk("rand_drain", 32'(bus.dec_valid), 0);
    chk("rand_addr",  32'(bus.instruction_address), 31);
    bus.dec_ready = 1'b1;

    // Asynchronous reset while a slot is pending
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("pre_rst_valid", 32'(bus.dec_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.dec_valid), 0);
    chk("async_rst_addr",  32'(bus.instruction_address), 0);
    chk("async_rst_done",  32'(done), 0);
    tick(); rst = 1'b0;

`ifdef FETCH_JUMP_EN
    // Jump flushes the pending slot and redirects fetch
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (bus.instruction_address != 5'd12 && guard < 50) begin
      tick(); guard++;
    end
    chk("reach_addr12", 32'(guard < 50), 1);
    bus.dec_ready = 1'b0;
    jump_en = 1'b1; jump_addr = 5'd20; tick(); jump_en = 1'b0;
    chk("jump_flush", 32'(bus.dec_valid), 0);
    chk("jump_addr",  32'(bus.instruction_address), 20);
    bus.dec_ready = 1'b1; tick();
    chk("jump_valid", 32'(bus.dec_valid), 1);
    chk("jump_pc",    32'(bus.dec_pc), 20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
